// File: rtl/mac_simd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_simd_pipe
// Brief    : Signed MAC with guard bits, full-width or LANES-way SIMD mode,
//            sticky per-lane saturation and a stallable output pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mac_simd_pipe #(
    parameter int LANE_W     = 8,
    parameter int LANES      = 2,
    parameter int GUARD      = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [2:0]                    instruction,
    input  logic [LANE_W*LANES-1:0]       multiplier,
    input  logic [LANE_W*LANES-1:0]       multiplicand,
    input  logic                          stall,
    output logic                          out_valid,
    output logic [GUARD*LANES-1:0]        protect,
    output logic [2*LANE_W*LANES-1:0]     result,
    output logic [LANES-1:0]              sat_flag
);

    localparam int c_data_w = LANE_W * LANES;
    localparam int c_res_w  = 2 * c_data_w;
    localparam int c_seg_w  = 2 * LANE_W + GUARD;
    localparam int c_acc_w  = LANES * c_seg_w;
    localparam int c_xt_w   = c_acc_w - c_res_w;

    localparam logic [2:0] c_op_mul_f = 3'b001;
    localparam logic [2:0] c_op_mac_f = 3'b010;
    localparam logic [2:0] c_op_sat_f = 3'b011;
    localparam logic [2:0] c_op_mul_s = 3'b101;
    localparam logic [2:0] c_op_mac_s = 3'b110;
    localparam logic [2:0] c_op_sat_s = 3'b111;

    logic [c_acc_w-1:0] r_acc;
    logic               r_acc_vld;
    logic [LANES-1:0]   r_sat;
    logic [c_acc_w-1:0] r_pipe_data [PIPE_DEPTH];
    logic               r_pipe_vld  [PIPE_DEPTH];

    // ---------------- full-width datapath ----------------
    logic signed [c_res_w-1:0] w_full_prod;
    logic [c_acc_w-1:0]        w_full_ext;
    logic [c_acc_w-1:0]        w_full_sum;
    logic [c_xt_w:0]           w_full_hi;
    logic                      w_full_ovf;
    logic [c_acc_w-1:0]        w_full_sat;

    assign w_full_prod = $signed(multiplier) * $signed(multiplicand);
    assign w_full_ext  = {{c_xt_w{w_full_prod[c_res_w-1]}}, w_full_prod};
    assign w_full_sum  = r_acc + w_full_ext;
    // Value fits the 2*DATA_W range only when guard bits and result MSB agree.
    assign w_full_hi   = r_acc[c_acc_w-1:c_res_w-1];
    assign w_full_ovf  = ~(&w_full_hi) & (|w_full_hi);
    assign w_full_sat  = !w_full_ovf ? r_acc :
                         r_acc[c_acc_w-1] ? {{(c_xt_w+1){1'b1}}, {(c_res_w-1){1'b0}}}
                                          : {{(c_xt_w+1){1'b0}}, {(c_res_w-1){1'b1}}};

    // ---------------- split datapath ----------------
    logic [c_acc_w-1:0] w_split_acc;
    logic [LANES-1:0]   w_lane_ovf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [2*LANE_W-1:0] w_prod;
        logic [c_seg_w-1:0]         w_cur;
        logic [c_seg_w-1:0]         w_prod_ext;
        logic [c_seg_w-1:0]         w_sum;
        logic [c_seg_w-1:0]         w_sat_val;
        logic [c_seg_w-1:0]         w_new;
        logic [GUARD:0]             w_hi;
        logic                       w_ovf;

        // Lane view gathers its guard nibble from the protect field.
        assign w_cur      = {r_acc[c_res_w + i*GUARD +: GUARD], r_acc[i*2*LANE_W +: 2*LANE_W]};
        assign w_prod     = $signed(multiplier[i*LANE_W +: LANE_W])
                          * $signed(multiplicand[i*LANE_W +: LANE_W]);
        assign w_prod_ext = {{GUARD{w_prod[2*LANE_W-1]}}, w_prod};
        assign w_sum      = w_cur + w_prod_ext;
        assign w_hi       = w_cur[c_seg_w-1:2*LANE_W-1];
        assign w_ovf      = ~(&w_hi) & (|w_hi);
        assign w_sat_val  = !w_ovf ? w_cur :
                            w_cur[c_seg_w-1] ? {{(GUARD+1){1'b1}}, {(2*LANE_W-1){1'b0}}}
                                             : {{(GUARD+1){1'b0}}, {(2*LANE_W-1){1'b1}}};

        always_comb begin
            case (instruction)
                c_op_mul_s: w_new = w_prod_ext;
                c_op_mac_s: w_new = w_sum;
                c_op_sat_s: w_new = w_sat_val;
                default:    w_new = w_cur;
            endcase
        end

        assign w_lane_ovf[i] = w_ovf;
        assign w_split_acc[c_res_w + i*GUARD +: GUARD]  = w_new[c_seg_w-1 -: GUARD];
        assign w_split_acc[i*2*LANE_W +: 2*LANE_W]      = w_new[2*LANE_W-1:0];
    end

    // ---------------- next-state selection ----------------
    logic [c_acc_w-1:0] w_acc_next;
    logic [LANES-1:0]   w_sat_next;

    always_comb begin
        w_acc_next = r_acc;
        w_sat_next = r_sat;
        if (in_valid) begin
            case (instruction)
                c_op_mul_f: w_acc_next = w_full_ext;
                c_op_mac_f: w_acc_next = w_full_sum;
                c_op_sat_f: begin
                    w_acc_next = w_full_sat;
                    if (w_full_ovf) w_sat_next[0] = 1'b1;
                end
                c_op_mul_s, c_op_mac_s: w_acc_next = w_split_acc;
                c_op_sat_s: begin
                    w_acc_next = w_split_acc;
                    w_sat_next = r_sat | w_lane_ovf;
                end
                default: begin
                    w_acc_next = '0;
                    w_sat_next = '0;
                end
            endcase
        end
    end

    // The registered accumulator is the first delay; the pipe adds PIPE_DEPTH-1... plus
    // the stage-0 register, so an update is seen PIPE_DEPTH edges after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_acc_vld <= 1'b0;
            r_sat     <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_pipe_data[k] <= '0;
                r_pipe_vld[k]  <= 1'b0;
            end
        end else if (!stall) begin
            r_acc     <= w_acc_next;
            r_acc_vld <= in_valid;
            r_sat     <= w_sat_next;
            r_pipe_data[PIPE_DEPTH-1] <= r_acc;
            r_pipe_vld[PIPE_DEPTH-1]  <= r_acc_vld;
            for (int k = 0; k < PIPE_DEPTH-1; k++) begin
                r_pipe_data[k] <= r_pipe_data[k+1];
                r_pipe_vld[k]  <= r_pipe_vld[k+1];
            end
        end
    end

    assign out_valid = r_pipe_vld[0];
    assign result    = r_pipe_data[0][c_res_w-1:0];
    assign protect   = r_pipe_data[0][c_acc_w-1:c_res_w];
    assign sat_flag  = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_simd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_simd_pipe
// Brief    : Directed plus randomized bench for mac_simd_pipe against an
//            arithmetic reference model of the accumulator and output delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_simd_pipe;

    localparam int c_lane_w = 8;
    localparam int c_lanes  = 2;
    localparam int c_guard  = 4;
    localparam int c_depth  = 2;
    localparam longint c_fmax = (longint'(1) <<< 31) - 1;
    localparam longint c_fmin = -(longint'(1) <<< 31);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  instruction = 3'b000;
    logic [15:0] multiplier = '0;
    logic [15:0] multiplicand = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [7:0]  protect;
    logic [31:0] result;
    logic [1:0]  sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: 40-bit accumulator image, sticky flags, output delay line.
    logic [39:0] m_acc = '0;
    logic [1:0]  m_sat = '0;
    logic [40:0] m_q[$];
    logic [40:0] m_exp = '0;

    mac_simd_pipe #(
        .LANE_W(c_lane_w), .LANES(c_lanes), .GUARD(c_guard), .PIPE_DEPTH(c_depth)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .multiplier(multiplier), .multiplicand(multiplicand), .stall(stall),
        .out_valid(out_valid), .protect(protect), .result(result), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int lane_val(input int i);
        logic [19:0] b;
        b = {m_acc[32 + i*4 +: 4], m_acc[i*16 +: 16]};
        return int'($signed(b));
    endfunction

    task automatic set_lane(input int i, input int v);
        logic [19:0] b;
        b = v[19:0];
        m_acc[32 + i*4 +: 4] = b[19:16];
        m_acc[i*16 +: 16]    = b[15:0];
    endtask

    task automatic model_edge(input logic rst_i, input logic stl, input logic vld,
                              input logic [2:0] ins, input logic [15:0] a, input logic [15:0] b);
        longint fa, fb, v;
        int la, lb, lv;
        if (rst_i) begin
            m_acc = '0;
            m_sat = '0;
            m_exp = '0;
            m_q.delete();
            for (int k = 0; k < c_depth; k++) m_q.push_back('0);
        end else if (!stl) begin
            fa = longint'($signed(a));
            fb = longint'($signed(b));
            if (vld) begin
                case (ins)
                    3'd1: begin v = fa * fb; m_acc = v[39:0]; end
                    3'd2: begin v = longint'($signed(m_acc)) + fa * fb; m_acc = v[39:0]; end
                    3'd3: begin
                        v = longint'($signed(m_acc));
                        if (v > c_fmax) begin v = c_fmax; m_sat[0] = 1'b1; end
                        else if (v < c_fmin) begin v = c_fmin; m_sat[0] = 1'b1; end
                        m_acc = v[39:0];
                    end
                    3'd5, 3'd6, 3'd7: begin
                        for (int i = 0; i < c_lanes; i++) begin
                            la = int'($signed(a[i*8 +: 8]));
                            lb = int'($signed(b[i*8 +: 8]));
                            if (ins == 3'd5) set_lane(i, la * lb);
                            else if (ins == 3'd6) set_lane(i, lane_val(i) + la * lb);
                            else begin
                                lv = lane_val(i);
                                if (lv > 32767) begin set_lane(i, 32767); m_sat[i] = 1'b1; end
                                else if (lv < -32768) begin set_lane(i, -32768); m_sat[i] = 1'b1; end
                            end
                        end
                    end
                    default: begin m_acc = '0; m_sat = '0; end
                endcase
            end
            m_exp = m_q.pop_front();
            m_q.push_back({vld, m_acc});
        end
    endtask

    task automatic step(input logic rst_i, input logic stl, input logic vld,
                        input logic [2:0] ins, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        reset = rst_i; stall = stl; in_valid = vld; instruction = ins;
        multiplier = a; multiplicand = b;
        @(posedge clk);
        model_edge(rst_i, stl, vld, ins, a, b);
        #1;
        check("result",    64'(result),    64'(m_exp[31:0]));
        check("protect",   64'(protect),   64'(m_exp[39:32]));
        check("out_valid", 64'(out_valid), 64'(m_exp[40]));
        check("sat_flag",  64'(sat_flag),  64'(m_sat));
    endtask

    task automatic op(input logic [2:0] ins, input logic [15:0] a, input logic [15:0] b);
        step(1'b0, 1'b0, 1'b1, ins, a, b);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    endtask

    task automatic drain();
        idle();
        idle();
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h8080;
            3: return 16'h7F7F;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        idle();
        check("rst_result", 64'(result), 64'h0);
        check("rst_prot",   64'(protect), 64'h0);
        check("rst_ov",     64'(out_valid), 64'h0);
        check("rst_sat",    64'(sat_flag), 64'h0);

        op(3'd1, 16'h8000, 16'h8000);
        op(3'd1, 16'hFFFD, 16'h0005);
        idle();
        check("mulf_min_res",  64'(result), 64'h40000000);
        check("mulf_min_prot", 64'(protect), 64'h00);
        check("mulf_min_ov",   64'(out_valid), 64'h1);
        idle();
        check("mulf_neg_res",  64'(result), 64'hFFFFFFF1);
        check("mulf_neg_prot", 64'(protect), 64'hFF);

        op(3'd1, 16'h7FFF, 16'h7FFF);
        op(3'd2, 16'h7FFF, 16'h7FFF);
        op(3'd2, 16'h7FFF, 16'h7FFF);
        drain();
        check("macf_res",  64'(result), 64'hBFFD0003);
        check("macf_prot", 64'(protect), 64'h00);
        op(3'd3, 16'h0, 16'h0);
        drain();
        check("satf_res",  64'(result), 64'h7FFFFFFF);
        check("satf_prot", 64'(protect), 64'h00);
        check("satf_flag", 64'(sat_flag), 64'h1);
        op(3'd0, 16'h0, 16'h0);
        drain();
        check("clr_res",  64'(result), 64'h0);
        check("clr_flag", 64'(sat_flag), 64'h0);

        op(3'd5, 16'h80FF, 16'h8002);
        drain();
        check("muls_res",  64'(result), 64'h4000FFFE);
        check("muls_prot", 64'(protect), 64'h0F);
        op(3'd6, 16'h80FF, 16'h8002);
        op(3'd6, 16'h80FF, 16'h8002);
        drain();
        check("macs_res",  64'(result), 64'hC000FFFA);
        check("macs_prot", 64'(protect), 64'h0F);
        op(3'd7, 16'h0, 16'h0);
        drain();
        check("sats_res",  64'(result), 64'h7FFFFFFA);
        check("sats_prot", 64'(protect), 64'h0F);
        check("sats_flag", 64'(sat_flag), 64'h2);

        op(3'd1, 16'd2, 16'd3);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 3'd2, 16'd4, 16'd5);
        op(3'd2, 16'd1, 16'd1);
        idle();
        check("stall_first",  64'(result), 64'd6);
        idle();
        check("stall_second", 64'(result), 64'd7);

        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, k[0] == 1'b0, 3'd2, 16'd1, 16'd1);
        op(3'd2, 16'h1234, 16'h0101);
        step(1'b1, 1'b0, 1'b1, 3'd2, 16'h1234, 16'h0101);
        check("rst_mid_res", 64'(result), 64'h0);
        check("rst_mid_ov",  64'(out_valid), 64'h0);
        check("rst_mid_sat", 64'(sat_flag), 64'h0);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_op(), rnd_op());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
